// File: rtl/pipe_test_seq.sv
// pipe_test_seq: run sequencer for a pipe-out pattern-generator test.
//
// A run is requested with start.  The sequencer latches the pattern
// configuration, holds the generator in reset for RESET_CYCLES cycles,
// pulses gen_throttle_set for one cycle, then counts host reads until
// cfg_length words have been read, the host goes quiet for TIMEOUT_CYCLES
// cycles, or abort is raised.
//
// Ports
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start, abort         one-cycle run request / cancel
//   cfg_mode             pattern mode (0 = count, 1 = LFSR), latched on start
//   cfg_throttle[31:0]   throttle pattern, latched on start
//   cfg_length[31:0]     words per run, latched on start
//   pipe_out_read        host read strobe (counted only in RUN)
//   pipe_out_ready       generator ready (a read without it is an underrun)
//   gen_reset            reset to the generator (high except in ARM/RUN)
//   gen_mode             latched mode
//   gen_throttle_val     latched throttle
//   gen_throttle_set     one-cycle throttle load strobe (ARM only)
//   busy, done           busy in RESET/ARM/RUN, done in DONE
//   word_count           reads counted in the current or last run
//   cycle_count          RUN cycles in the current or last run (saturating)
//   underrun, timeout, aborted   sticky status, cleared by the next start
module pipe_test_seq #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_mode,
    input  logic [31:0] cfg_throttle,
    input  logic [31:0] cfg_length,
    input  logic        pipe_out_read,
    input  logic        pipe_out_ready,
    output logic        gen_reset,
    output logic        gen_mode,
    output logic [31:0] gen_throttle_val,
    output logic        gen_throttle_set,
    output logic        busy,
    output logic        done,
    output logic [31:0] word_count,
    output logic [31:0] cycle_count,
    output logic        underrun,
    output logic        timeout,
    output logic        aborted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]  RST_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [31:0] thr_q, thr_d;
    logic [31:0] len_q, len_d;
    logic [31:0] wc_q, wc_d;
    logic [31:0] cc_q, cc_d;
    logic [31:0] idle_q, idle_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic        ur_q, ur_d;
    logic        to_q, to_d;
    logic        ab_q, ab_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            len_q     <= '0;
            wc_q      <= '0;
            cc_q      <= '0;
            idle_q    <= '0;
            rst_cnt_q <= '0;
            ur_q      <= 1'b0;
            to_q      <= 1'b0;
            ab_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            len_q     <= len_d;
            wc_q      <= wc_d;
            cc_q      <= cc_d;
            idle_q    <= idle_d;
            rst_cnt_q <= rst_cnt_d;
            ur_q      <= ur_d;
            to_q      <= to_d;
            ab_q      <= ab_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        len_d     = len_q;
        wc_d      = wc_q;
        cc_d      = cc_q;
        idle_d    = idle_q;
        rst_cnt_d = rst_cnt_q;
        ur_d      = ur_q;
        to_d      = to_q;
        ab_d      = ab_q;

        case (state_q)
            // start beats abort here; abort alone is ignored outside a run
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d    = cfg_mode;
                    thr_d     = cfg_throttle;
                    len_d     = cfg_length;
                    wc_d      = '0;
                    cc_d      = '0;
                    idle_d    = '0;
                    rst_cnt_d = '0;
                    ur_d      = 1'b0;
                    to_d      = 1'b0;
                    ab_d      = 1'b0;
                    state_d   = S_RESET;
                end
            end
            S_RESET: begin
                if (abort) begin
                    ab_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d = S_ARM;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            S_ARM: begin
                idle_d = '0;
                if (abort) begin
                    ab_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = (len_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // abort freezes the counters on its own cycle and outranks
                // both completion and timeout
                if (abort) begin
                    ab_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cc_d = (cc_q == 32'hFFFF_FFFF) ? cc_q : cc_q + 32'd1;
                    if (pipe_out_read) begin
                        wc_d   = wc_q + 32'd1;
                        idle_d = '0;
                        if (!pipe_out_ready) begin
                            ur_d = 1'b1;
                        end
                        if (wc_q + 32'd1 == len_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idle_d = idle_q + 32'd1;
                        if (idle_q + 32'd1 == TO_LIMIT) begin
                            to_d    = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gen_reset        = (state_q != S_ARM) && (state_q != S_RUN);
    assign gen_throttle_set = (state_q == S_ARM);
    assign busy             = (state_q == S_RESET) || (state_q == S_ARM) || (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign gen_mode         = mode_q;
    assign gen_throttle_val = thr_q;
    assign word_count       = wc_q;
    assign cycle_count      = cc_q;
    assign underrun         = ur_q;
    assign timeout          = to_q;
    assign aborted          = ab_q;

endmodule

// File: tb/tb_pipe_test_seq.sv
module tb_pipe_test_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, cfg_mode;
    logic [31:0] cfg_throttle, cfg_length;
    logic        pipe_out_read, pipe_out_ready;
    logic        gen_reset, gen_mode, gen_throttle_set;
    logic [31:0] gen_throttle_val;
    logic        busy, done;
    logic [31:0] word_count, cycle_count;
    logic        underrun, timeout, aborted;

    always #5 clk = ~clk;

    pipe_test_seq #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_throttle(cfg_throttle), .cfg_length(cfg_length),
        .pipe_out_read(pipe_out_read), .pipe_out_ready(pipe_out_ready),
        .gen_reset(gen_reset), .gen_mode(gen_mode), .gen_throttle_val(gen_throttle_val),
        .gen_throttle_set(gen_throttle_set), .busy(busy), .done(done),
        .word_count(word_count), .cycle_count(cycle_count),
        .underrun(underrun), .timeout(timeout), .aborted(aborted)
    );

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] thr;
        logic [31:0] len;
        int          n_reads;      // reads issued in RUN
        int          gap;          // idle cycles between reads
        int          ur_idx;       // read index issued with ready low (-1: none)
        int          abort_after;  // abort once this many reads done (-1: none)
        logic        e_done;
        logic [31:0] e_wc;
        logic [31:0] e_cc;
        logic        e_ur, e_to, e_ab;
    } vec_t;

    vec_t vecs[6];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic mode, input logic [31:0] thr,
                                input logic [31:0] len, input int n_reads, input int gap,
                                input int ur_idx, input int abort_after, input logic e_done,
                                input logic [31:0] e_wc, input logic [31:0] e_cc,
                                input logic e_ur, input logic e_to, input logic e_ab);
        vec_t v;
        v.name = name; v.mode = mode; v.thr = thr; v.len = len;
        v.n_reads = n_reads; v.gap = gap; v.ur_idx = ur_idx; v.abort_after = abort_after;
        v.e_done = e_done; v.e_wc = e_wc; v.e_cc = e_cc;
        v.e_ur = e_ur; v.e_to = e_to; v.e_ab = e_ab;
        return v;
    endfunction

    // Drive the start request and record what the run must end with.
    task automatic start_run(input vec_t v);
        @(negedge clk);
        start = 1'b1; cfg_mode = v.mode; cfg_throttle = v.thr; cfg_length = v.len;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step the run to its end, driving reads/abort, then pop and compare.
    task automatic finish_run(input vec_t v);
        int   rst_cyc = 0;
        int   ts = 0;
        int   run_cyc = 0;
        int   reads = 0;
        bit   ended = 0;
        vec_t e;
        for (int cyc = 0; cyc < 200; cyc++) begin
            pipe_out_read = 1'b0; pipe_out_ready = 1'b1; abort = 1'b0; start = 1'b0;
            if (!busy) begin
                ended = 1;
                break;
            end
            if (done) chk({v.name, "_done_busy"}, 32'(done & busy), 32'd0);
            if (gen_reset) begin
                rst_cyc++;
                // a start while busy must change nothing
                if (rst_cyc == 2) begin
                    start = 1'b1; cfg_mode = ~v.mode; cfg_throttle = ~v.thr; cfg_length = v.len + 5;
                end
            end else if (gen_throttle_set) begin
                ts++;
            end else begin
                if (v.abort_after >= 0 && reads == v.abort_after) begin
                    abort = 1'b1;
                end else if (reads < v.n_reads && (run_cyc % (v.gap + 1)) == 0) begin
                    pipe_out_read  = 1'b1;
                    pipe_out_ready = (reads != v.ur_idx);
                    reads++;
                end
                run_cyc++;
            end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; pipe_out_read = 1'b0;
        chk({v.name, "_ended"}, 32'(ended), 32'd1);
        if (exp_q.size() == 0) begin
            chk({v.name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, "_reset_cycles"}, 32'(rst_cyc), 32'd4);
            chk({e.name, "_throttle_pulses"}, 32'(ts), 32'd1);
            chk({e.name, "_done"}, 32'(done), 32'(e.e_done));
            chk({e.name, "_busy"}, 32'(busy), 32'd0);
            chk({e.name, "_word_count"}, word_count, e.e_wc);
            chk({e.name, "_cycle_count"}, cycle_count, e.e_cc);
            chk({e.name, "_underrun"}, 32'(underrun), 32'(e.e_ur));
            chk({e.name, "_timeout"}, 32'(timeout), 32'(e.e_to));
            chk({e.name, "_aborted"}, 32'(aborted), 32'(e.e_ab));
            chk({e.name, "_gen_reset"}, 32'(gen_reset), 32'd1);
            chk({e.name, "_throttle_set"}, 32'(gen_throttle_set), 32'd0);
            chk({e.name, "_gen_mode"}, 32'(gen_mode), 32'(e.mode));
            chk({e.name, "_throttle_val"}, gen_throttle_val, e.thr);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_gen_reset"}, 32'(gen_reset), 32'd1);
        chk({tag, "_throttle_set"}, 32'(gen_throttle_set), 32'd0);
        chk({tag, "_gen_mode"}, 32'(gen_mode), 32'd0);
        chk({tag, "_throttle_val"}, gen_throttle_val, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_word_count"}, word_count, 32'd0);
        chk({tag, "_cycle_count"}, cycle_count, 32'd0);
        chk({tag, "_flags"}, {29'd0, underrun, timeout, aborted}, 32'd0);
    endtask

    initial begin
        vec_t vb, vr;
        bit   in_run;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0;
        cfg_throttle = '0; cfg_length = '0; pipe_out_read = 1'b0; pipe_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values("por");
        reset_n = 1'b1;

        //          name          mode  thr            len  n  gap ur  ab  done wc  cc  ur to ab
        vecs[0] = mk("basic8",    1'b1, 32'hFFFF_FFFF, 8,   8, 0, -1, -1, 1'b1, 8,  8,  0, 0, 0);
        vecs[1] = mk("len0",      1'b0, 32'h0000_0000, 0,   0, 0, -1, -1, 1'b1, 0,  0,  0, 0, 0);
        vecs[2] = mk("underrun",  1'b0, 32'h5555_AAAA, 16, 16, 0,  5, -1, 1'b1, 16, 16, 1, 0, 0);
        vecs[3] = mk("abort2",    1'b1, 32'h0000_0001, 4,   4, 0, -1,  2, 1'b0, 2,  2,  0, 0, 1);
        vecs[4] = mk("timeout",   1'b0, 32'h8000_0001, 4,   1, 0, -1, -1, 1'b1, 1,  17, 0, 1, 0);
        vecs[5] = mk("gapped",    1'b0, 32'h1234_5678, 3,   3, 1, -1, -1, 1'b1, 3,  5,  0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i]);
            finish_run(vecs[i]);
            if (i == 0) begin
                // abort and reads in DONE change nothing
                @(negedge clk);
                abort = 1'b1; pipe_out_read = 1'b1;
                @(negedge clk);
                abort = 1'b0; pipe_out_read = 1'b0;
                chk("done_abort_done", 32'(done), 32'd1);
                chk("done_abort_flag", 32'(aborted), 32'd0);
                chk("done_read_wc", word_count, 32'd8);
            end
        end

        // Reset asserted in the middle of a run abandons it silently.
        vr = mk("midrun", 1'b1, 32'h0000_00A5, 8, 8, 0, -1, -1, 1'b1, 8, 8, 0, 0, 0);
        start_run(vr);
        in_run = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy && !gen_reset && !gen_throttle_set) begin
                in_run = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrun_reached_run", 32'(in_run), 32'd1);
        pipe_out_read = 1'b1;
        @(negedge clk);
        pipe_out_read = 1'b0;
        chk("midrun_wc_before", word_count, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("midrun_async");
        void'(exp_q.pop_front());

        // Start and abort together right after release: start wins.
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b1; abort = 1'b1; cfg_mode = 1'b1; cfg_throttle = 32'h0F0F_0F0F; cfg_length = 2;
        vb = mk("post_reset", 1'b1, 32'h0F0F_0F0F, 2, 2, 0, -1, -1, 1'b1, 2, 2, 0, 0, 0);
        exp_q.push_back(vb);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("post_reset_busy", 32'(busy), 32'd1);
        chk("post_reset_aborted", 32'(aborted), 32'd0);
        chk("post_reset_gen_mode", 32'(gen_mode), 32'd1);
        finish_run(vb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
